// File: rtl/lc3_decode.sv
`default_nettype none
// ============================================================================
// Module  : lc3_decode
// Brief   : LC3 Decode pipeline stage. Registers the fetched instruction and
//           its NPC on an accept strobe and produces registered Execute,
//           Writeback and Memory control words decoded from the incoming
//           opcode. Opcodes outside the supported subset raise illegal_op.
// Revision: 1.0 - initial release
// ============================================================================
module lc3_decode #(
    parameter int DATA_WIDTH           = 16,
    parameter bit ZERO_CTRL_ON_ILLEGAL = 1'b1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable_decode,
    input  logic [DATA_WIDTH-1:0] instr_dout,
    input  logic [DATA_WIDTH-1:0] npc_in,
    output logic [DATA_WIDTH-1:0] IR,
    output logic [DATA_WIDTH-1:0] npc_out,
    output logic [5:0]            E_Control,
    output logic [1:0]            W_Control,
    output logic                  Mem_Control,
    output logic                  decode_valid,
    output logic                  illegal_op
);

    // ------------------------------------------------------------------------
    // Opcode encodings
    // ------------------------------------------------------------------------
    localparam logic [3:0] C_OP_BR   = 4'b0000;
    localparam logic [3:0] C_OP_ADD  = 4'b0001;
    localparam logic [3:0] C_OP_LD   = 4'b0010;
    localparam logic [3:0] C_OP_ST   = 4'b0011;
    localparam logic [3:0] C_OP_JSR  = 4'b0100;
    localparam logic [3:0] C_OP_AND  = 4'b0101;
    localparam logic [3:0] C_OP_LDR  = 4'b0110;
    localparam logic [3:0] C_OP_STR  = 4'b0111;
    localparam logic [3:0] C_OP_RTI  = 4'b1000;
    localparam logic [3:0] C_OP_NOT  = 4'b1001;
    localparam logic [3:0] C_OP_LDI  = 4'b1010;
    localparam logic [3:0] C_OP_STI  = 4'b1011;
    localparam logic [3:0] C_OP_JMP  = 4'b1100;
    localparam logic [3:0] C_OP_RES  = 4'b1101;
    localparam logic [3:0] C_OP_LEA  = 4'b1110;
    localparam logic [3:0] C_OP_TRAP = 4'b1111;

    // ALU function select
    localparam logic [1:0] C_ALU_ADD = 2'b00;
    localparam logic [1:0] C_ALU_AND = 2'b01;
    localparam logic [1:0] C_ALU_NOT = 2'b10;

    // Address-generation source select (pcselect1)
    localparam logic [1:0] C_PC1_NONE  = 2'b00;
    localparam logic [1:0] C_PC1_OFF9  = 2'b01;
    localparam logic [1:0] C_PC1_OFF6  = 2'b10;
    localparam logic [1:0] C_PC1_ZERO  = 2'b11;

    // Writeback source select
    localparam logic [1:0] C_WB_ALU = 2'b00;
    localparam logic [1:0] C_WB_MEM = 2'b01;
    localparam logic [1:0] C_WB_NPC = 2'b10;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] ir_q,      ir_d;
    logic [DATA_WIDTH-1:0] npc_q,     npc_d;
    logic [5:0]            e_ctrl_q,  e_ctrl_d;
    logic [1:0]            w_ctrl_q,  w_ctrl_d;
    logic                  mem_ctrl_q, mem_ctrl_d;
    logic                  valid_q,   valid_d;
    logic                  illegal_q, illegal_d;

    // ------------------------------------------------------------------------
    // Raw decode of the incoming opcode (not the held IR)
    // ------------------------------------------------------------------------
    logic [3:0] w_opcode;
    logic [1:0] w_alu_ctrl;
    logic [1:0] w_pcsel1;
    logic       w_pcsel2;
    logic       w_op2sel;
    logic [1:0] w_wb_sel;
    logic       w_mem_ind;
    logic       w_illegal;
    logic [5:0] w_e_raw;
    logic [5:0] w_e_ctrl;
    logic [1:0] w_w_ctrl;
    logic       w_m_ctrl;

    assign w_opcode = instr_dout[DATA_WIDTH-1 -: 4];

    // Translate the 4-bit opcode into individual control fields; unlisted
    // fields stay at zero so each opcode only sets what it uses.
    always_comb begin
        w_alu_ctrl = C_ALU_ADD;
        w_pcsel1   = C_PC1_NONE;
        w_pcsel2   = 1'b0;
        w_op2sel   = 1'b0;
        w_wb_sel   = C_WB_ALU;
        w_mem_ind  = 1'b0;
        w_illegal  = 1'b0;
        case (w_opcode)
            C_OP_ADD: begin
                w_alu_ctrl = C_ALU_ADD;
                w_op2sel   = ~instr_dout[5];   // bit5=0 selects register VSR2
            end
            C_OP_AND: begin
                w_alu_ctrl = C_ALU_AND;
                w_op2sel   = ~instr_dout[5];
            end
            C_OP_NOT: begin
                w_alu_ctrl = C_ALU_NOT;
            end
            C_OP_BR, C_OP_ST: begin
                w_pcsel1 = C_PC1_OFF9;
                w_pcsel2 = 1'b1;
            end
            C_OP_LD: begin
                w_pcsel1 = C_PC1_OFF9;
                w_pcsel2 = 1'b1;
                w_wb_sel = C_WB_MEM;
            end
            C_OP_LDI: begin
                w_pcsel1  = C_PC1_OFF9;
                w_pcsel2  = 1'b1;
                w_wb_sel  = C_WB_MEM;
                w_mem_ind = 1'b1;
            end
            C_OP_STI: begin
                w_pcsel1  = C_PC1_OFF9;
                w_pcsel2  = 1'b1;
                w_mem_ind = 1'b1;
            end
            C_OP_LEA: begin
                w_pcsel1 = C_PC1_OFF9;
                w_pcsel2 = 1'b1;
                w_wb_sel = C_WB_NPC;
            end
            C_OP_LDR: begin
                w_pcsel1 = C_PC1_OFF6;
                w_wb_sel = C_WB_MEM;
            end
            C_OP_STR: begin
                w_pcsel1 = C_PC1_OFF6;
            end
            C_OP_JMP: begin
                w_pcsel1 = C_PC1_ZERO;
            end
            C_OP_JSR, C_OP_RTI, C_OP_RES, C_OP_TRAP: begin
                w_illegal = 1'b1;
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
    end

    assign w_e_raw = {w_alu_ctrl, w_pcsel1, w_pcsel2, w_op2sel};

    // Illegal opcodes either force the control words to zero or pass the
    // default decode through, depending on the build option.
    generate
        if (ZERO_CTRL_ON_ILLEGAL) begin : g_zero_on_illegal
            assign w_e_ctrl = w_illegal ? 6'b000000 : w_e_raw;
            assign w_w_ctrl = w_illegal ? 2'b00     : w_wb_sel;
            assign w_m_ctrl = w_illegal ? 1'b0      : w_mem_ind;
        end else begin : g_default_on_illegal
            assign w_e_ctrl = w_e_raw;
            assign w_w_ctrl = w_wb_sel;
            assign w_m_ctrl = w_mem_ind;
        end
    endgenerate

    // Next-state selection: load everything on accept, otherwise hold data
    // and control while dropping the valid flag.
    always_comb begin
        ir_d       = ir_q;
        npc_d      = npc_q;
        e_ctrl_d   = e_ctrl_q;
        w_ctrl_d   = w_ctrl_q;
        mem_ctrl_d = mem_ctrl_q;
        illegal_d  = illegal_q;
        valid_d    = 1'b0;
        if (enable_decode) begin
            ir_d       = instr_dout;
            npc_d      = npc_in;
            e_ctrl_d   = w_e_ctrl;
            w_ctrl_d   = w_w_ctrl;
            mem_ctrl_d = w_m_ctrl;
            illegal_d  = w_illegal;
            valid_d    = 1'b1;
        end
    end

    // Pipeline register with synchronous reset taking priority over accept.
    always_ff @(posedge clock) begin
        if (reset) begin
            ir_q       <= '0;
            npc_q      <= '0;
            e_ctrl_q   <= 6'b000000;
            w_ctrl_q   <= 2'b00;
            mem_ctrl_q <= 1'b0;
            valid_q    <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            ir_q       <= ir_d;
            npc_q      <= npc_d;
            e_ctrl_q   <= e_ctrl_d;
            w_ctrl_q   <= w_ctrl_d;
            mem_ctrl_q <= mem_ctrl_d;
            valid_q    <= valid_d;
            illegal_q  <= illegal_d;
        end
    end

    assign IR           = ir_q;
    assign npc_out      = npc_q;
    assign E_Control    = e_ctrl_q;
    assign W_Control    = w_ctrl_q;
    assign Mem_Control  = mem_ctrl_q;
    assign decode_valid = valid_q;
    assign illegal_op   = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_lc3_decode.sv
`default_nettype none
// ============================================================================
// Module  : tb_lc3_decode
// Brief   : Directed self-checking bench for the lc3_decode stage.
// Revision: 1.0 - initial release
// ============================================================================
module tb_lc3_decode;

    logic        clock;
    logic        reset;
    logic        enable_decode;
    logic [15:0] instr_dout;
    logic [15:0] npc_in;
    logic [15:0] IR;
    logic [15:0] npc_out;
    logic [5:0]  E_Control;
    logic [1:0]  W_Control;
    logic        Mem_Control;
    logic        decode_valid;
    logic        illegal_op;

    int r_tests;
    int r_fails;

    lc3_decode #(
        .DATA_WIDTH          (16),
        .ZERO_CTRL_ON_ILLEGAL(1'b1)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .enable_decode(enable_decode),
        .instr_dout   (instr_dout),
        .npc_in       (npc_in),
        .IR           (IR),
        .npc_out      (npc_out),
        .E_Control    (E_Control),
        .W_Control    (W_Control),
        .Mem_Control  (Mem_Control),
        .decode_valid (decode_valid),
        .illegal_op   (illegal_op)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts and reports.
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        r_tests++;
        if (obs !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Compare every output against hand-derived values.
    task automatic check_all(input string tag, input logic [15:0] ir, input logic [15:0] npc,
                             input logic [5:0] e, input logic [1:0] w, input logic m,
                             input logic v, input logic il);
        check({tag, ".IR"},    {16'd0, IR},           {16'd0, ir});
        check({tag, ".NPC"},   {16'd0, npc_out},      {16'd0, npc});
        check({tag, ".E"},     {26'd0, E_Control},    {26'd0, e});
        check({tag, ".W"},     {30'd0, W_Control},    {30'd0, w});
        check({tag, ".MEM"},   {31'd0, Mem_Control},  {31'd0, m});
        check({tag, ".VALID"}, {31'd0, decode_valid}, {31'd0, v});
        check({tag, ".ILL"},   {31'd0, illegal_op},   {31'd0, il});
    endtask

    // Drive inputs, then advance one edge and settle past it.
    task automatic step(input logic en, input logic [15:0] ins, input logic [15:0] npc);
        enable_decode = en;
        instr_dout    = ins;
        npc_in        = npc;
        @(posedge clock);
        #1;
    endtask

    initial begin
        r_tests = 0;
        r_fails = 0;
        reset         = 1'b1;
        enable_decode = 1'b0;
        instr_dout    = 16'h0000;
        npc_in        = 16'h0000;
        @(negedge clock);

        // Reset for two cycles
        step(1'b0, 16'h0000, 16'h0000);
        step(1'b0, 16'h0000, 16'h0000);
        check_all("reset", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;

        // ALU group, back-to-back
        step(1'b1, 16'h12A3, 16'h3001);
        check_all("add_imm", 16'h12A3, 16'h3001, 6'b000000, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h1283, 16'h3002);
        check_all("add_reg", 16'h1283, 16'h3002, 6'b000001, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h5283, 16'h3003);
        check_all("and_reg", 16'h5283, 16'h3003, 6'b010001, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h52A3, 16'h3004);
        check_all("and_imm", 16'h52A3, 16'h3004, 6'b010000, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h927F, 16'h3005);
        check_all("not", 16'h927F, 16'h3005, 6'b100000, 2'b00, 1'b0, 1'b1, 1'b0);

        // Memory and address group
        step(1'b1, 16'hA205, 16'h3006);
        check_all("ldi", 16'hA205, 16'h3006, 6'b000110, 2'b01, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h6285, 16'h3007);
        check_all("ldr", 16'h6285, 16'h3007, 6'b001000, 2'b01, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'hE1FF, 16'h3008);
        check_all("lea", 16'hE1FF, 16'h3008, 6'b000110, 2'b10, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h2403, 16'h3009);
        check_all("ld", 16'h2403, 16'h3009, 6'b000110, 2'b01, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h3403, 16'h300A);
        check_all("st", 16'h3403, 16'h300A, 6'b000110, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'hB403, 16'h300B);
        check_all("sti", 16'hB403, 16'h300B, 6'b000110, 2'b00, 1'b1, 1'b1, 1'b0);
        step(1'b1, 16'h7445, 16'h300C);
        check_all("str", 16'h7445, 16'h300C, 6'b001000, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h0E02, 16'h300D);
        check_all("br", 16'h0E02, 16'h300D, 6'b000110, 2'b00, 1'b0, 1'b1, 1'b0);

        // Illegal opcodes, then recovery
        step(1'b1, 16'hF025, 16'h300E);
        check_all("trap", 16'hF025, 16'h300E, 6'b000000, 2'b00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'hC1C0, 16'h300F);
        check_all("jmp", 16'hC1C0, 16'h300F, 6'b001100, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 16'h4801, 16'h3010);
        check_all("jsr", 16'h4801, 16'h3010, 6'b000000, 2'b00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'h8000, 16'h3011);
        check_all("rti", 16'h8000, 16'h3011, 6'b000000, 2'b00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 16'hD123, 16'h3012);
        check_all("res", 16'hD123, 16'h3012, 6'b000000, 2'b00, 1'b0, 1'b1, 1'b1);

        // Hold while not enabled, with changing inputs (including X)
        step(1'b1, 16'h1283, 16'h4000);
        check_all("pre_hold", 16'h1283, 16'h4000, 6'b000001, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 16'hA205, 16'h5555);
        check_all("hold1", 16'h1283, 16'h4000, 6'b000001, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'hF025, 16'hAAAA);
        check_all("hold2", 16'h1283, 16'h4000, 6'b000001, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 16'hxxxx, 16'hxxxx);
        check_all("hold3", 16'h1283, 16'h4000, 6'b000001, 2'b00, 1'b0, 1'b0, 1'b0);

        // Reset wins over a simultaneous accept
        reset = 1'b1;
        step(1'b1, 16'hA205, 16'h6000);
        check_all("rst_win", 16'h0000, 16'h0000, 6'b000000, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        step(1'b0, 16'h0000, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule
`default_nettype wire
